// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared PS/2 definitions used by the host transmitter and the receiver.
//   host_tx_state_t : state encoding of the host-to-device transmitter
//   PS2_FRAME_BITS  : start + 8 data + parity + stop
//   odd_parity()    : parity bit that makes the 9-bit {parity,data} odd
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } host_tx_state_t;

  localparam int PS2_FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge pulse.
//   clk, rst : system clock, synchronous active-high reset
//   line_i   : raw asynchronous line level
//   sync_o   : synchronized level
//   fall_o   : one-cycle pulse when the synchronized level goes 1 -> 0
// All flops reset to 1 (idle bus level) so reset release never produces a
// spurious falling edge.
// ---------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: inhibits the clock, issues request-to-send,
// shifts the byte out on device clock falling edges and reports the result.
//   clk, rst                 : system clock, synchronous active-high reset
//   tx_valid/tx_ready/tx_data: command byte handshake (accepted in IDLE only)
//   kbd_clk_i, kbd_data_i    : raw open-drain line levels (asynchronous)
//   kbd_clk_oe, kbd_data_oe  : 1 pulls the corresponding line low
//   busy                     : frame in progress (used to gate the receiver)
//   tx_done/tx_ack           : end-of-frame pulse, ack=1 when device ACKed
//   tx_err                   : pulse when the device stops clocking
// Optional build macro PS2_HOST_TX_RETRY_EN: a NACK or timeout restarts the
// frame from INHIBIT with the latched byte, up to 2 retries.
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 16_000_000,
  parameter int INHIBIT_US     = 100,
  parameter int TIMEOUT_CYCLES = 240_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       kbd_clk_i,
  output logic       kbd_clk_oe,
  input  logic       kbd_data_i,
  output logic       kbd_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack,
  output logic       tx_err
);

  localparam int INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int INH_W          = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
  // Start bit is driven during REQ, so only data+parity+stop are shifted.
  localparam int SHIFT_W        = PS2_FRAME_BITS - 1;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  // Line synchronizers
  logic clk_sync;
  logic clk_fall;
  logic data_sync;
  logic data_fall_unused;  // data edges carry no meaning for the host side

  ps2_line_sync u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (kbd_clk_i),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (kbd_data_i),
    .sync_o (data_sync),
    .fall_o (data_fall_unused)
  );

  // State
  host_tx_state_t     state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               ack_q, ack_d;

  logic clk_oe_q, clk_oe_d;
  logic data_oe_q, data_oe_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic tx_ack_q, tx_ack_d;
  logic err_q, err_d;
  logic ready_q, ready_d;

`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0] retry_q, retry_d;
  logic [7:0] byte_q, byte_d;
`endif

  logic frame_end;
  logic timeout_hit;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    inh_cnt_d   = inh_cnt_q;
    to_cnt_d    = to_cnt_q;
    ack_d       = ack_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_ack_d    = tx_ack_q;
    err_d       = 1'b0;
    ready_d     = ready_q;
    frame_end   = 1'b0;
    timeout_hit = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_d     = retry_q;
    byte_d      = byte_q;
`endif

    case (state_q)
      IDLE: begin
        ready_d   = 1'b1;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (tx_valid && ready_q) begin
          shift_d   = {1'b1, odd_parity(tx_data), tx_data};
          inh_cnt_d = '0;
          state_d   = INHIBIT;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
          byte_d    = tx_data;
          retry_d   = 2'd0;
`endif
        end
      end

      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        if (inh_cnt_q == INH_LAST) begin
          state_d   = REQ;
          data_oe_d = 1'b1;  // start bit, clock still held low
        end
      end

      REQ: begin
        state_d   = SEND;
        clk_oe_d  = 1'b0;    // hand the clock to the device
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end

      SEND: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[SHIFT_W-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          to_cnt_d  = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = ACK;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
        end
      end

      ACK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_fall) begin
          ack_d    = ~data_sync;  // device pulls data low to acknowledge
          to_cnt_d = '0;
          state_d  = WAIT_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
        end
      end

      WAIT_IDLE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_sync && data_sync) begin
          frame_end = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_end) begin
      done_d   = 1'b1;
      tx_ack_d = ack_q;
      busy_d   = 1'b0;
      state_d  = IDLE;
    end

    if (timeout_hit) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
      busy_d    = 1'b0;
      state_d   = IDLE;
    end

`ifdef PS2_HOST_TX_RETRY_EN
    // Failed attempt with retries left: silently restart the whole frame.
    if (((frame_end && !ack_q) || timeout_hit) && (retry_q != 2'd2)) begin
      retry_d   = retry_q + 2'd1;
      shift_d   = {1'b1, odd_parity(byte_q), byte_q};
      inh_cnt_d = '0;
      state_d   = INHIBIT;
      clk_oe_d  = 1'b1;
      data_oe_d = 1'b0;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      tx_ack_d  = tx_ack_q;
      err_d     = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_ack_q  <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q   <= '0;
      byte_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      ack_q     <= ack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_ack_q  <= tx_ack_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q   <= retry_d;
      byte_q    <= byte_d;
`endif
    end
  end

  assign tx_ready    = ready_q;
  assign kbd_clk_oe  = clk_oe_q;
  assign kbd_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_ack      = tx_ack_q;
  assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed + randomized bench for ps2_host_tx with a simple PS/2 device model
// on wired-AND lines. Scaled parameters keep frames and timeouts short:
// 100 inhibit cycles, 3000 timeout cycles.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int INH_US = 100;
  localparam int TO_CYC = 3000;
  localparam int INH    = CLK_HZ / 1_000_000 * INH_US;
  localparam int H      = 20;  // device half clock period in system cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       kbd_clk_i;
  logic       kbd_clk_oe;
  logic       kbd_data_i;
  logic       kbd_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_ack;
  logic       tx_err;

  logic dev_clk_rel  = 1'b1;
  logic dev_data_rel = 1'b1;

  assign kbd_clk_i  = dev_clk_rel & ~kbd_clk_oe;
  assign kbd_data_i = dev_data_rel & ~kbd_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .INHIBIT_US     (INH_US),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .kbd_clk_i   (kbd_clk_i),
    .kbd_clk_oe  (kbd_clk_oe),
    .kbd_data_i  (kbd_data_i),
    .kbd_data_oe (kbd_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_ack      (tx_ack),
    .tx_err      (tx_err)
  );

  int checks   = 0;
  int failures = 0;

  // Pulse monitor
  int   done_cnt = 0;
  int   err_cnt  = 0;
  logic last_ack = 1'b0;
  logic busy_at_done = 1'b0;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt     = done_cnt + 1;
      last_ack     = tx_ack;
      busy_at_done = busy;
    end
    if (tx_err === 1'b1) begin
      err_cnt = err_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  // Reference: the line level the device should read after falling edge k+1.
  function automatic logic frame_bit(input logic [7:0] data, input int k);
    int ones;
    ones = $countones(data);
    if (k < 8) return logic'((int'(data) >> k) & 1);
    if (k == 8) return (ones % 2 == 0) ? 1'b1 : 1'b0;
    return 1'b1;
  endfunction

  // Offers a byte and checks the inhibit / request sequence. Returns at the
  // first SEND cycle.
  task automatic start_frame(input logic [7:0] data, input bit hold);
    int n;
    tx_data  = data;
    tx_valid = 1'b1;
    tick();
    check("accept_busy", busy, 1);
    check("accept_ready", tx_ready, 0);
    if (hold) tx_data = data ^ 8'hA5;
    else      tx_valid = 1'b0;
    n = 0;
    while (kbd_clk_oe === 1'b1 && kbd_data_oe === 1'b0 && n < INH + 10) begin
      n++;
      tick();
    end
    check("inhibit_len", n, INH);
    check("req_clk_oe", kbd_clk_oe, 1);
    check("req_data_oe", kbd_data_oe, 1);
    tick();
    check("send_clk_oe", kbd_clk_oe, 0);
    check("send_data_oe", kbd_data_oe, 1);
  endtask

  // Device clocks nedges falling edges and reads the line while clock is high.
  task automatic send_edges(input logic [7:0] data, input int nedges);
    wait_cycles(10);
    check("start_bit", kbd_data_i, 0);
    for (int k = 0; k < nedges; k++) begin
      dev_clk_rel = 1'b0;
      wait_cycles(H);
      dev_clk_rel = 1'b1;
      wait_cycles(H);
      check($sformatf("bit%0d_%02h", k, data), kbd_data_i, frame_bit(data, k));
    end
  endtask

  task automatic full_frame(input logic [7:0] data, input bit dev_ack, input bit hold);
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(data, hold);
    send_edges(data, 10);
    check("stop_released", kbd_data_oe, 0);
    if (hold) tx_valid = 1'b0;
    // Edge 11: device drives data low to ACK, leaves it high to NACK.
    dev_data_rel = ~dev_ack;
    wait_cycles(5);
    dev_clk_rel = 1'b0;
    wait_cycles(H);
    dev_clk_rel = 1'b1;
    wait_cycles(5);
    dev_data_rel = 1'b1;
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      n++;
      tick();
    end
    check("done_count", done_cnt - d0, 1);
    check("done_ack", last_ack, dev_ack);
    check("done_busy_low", busy_at_done, 0);
    check("no_err", err_cnt - e0, 0);
    tick();
    check("ready_after_done", tx_ready, 1);
    check("done_single", tx_done, 0);
  endtask

  initial begin
    int d0, e0, n;
    logic [7:0] rb;
    bit ra;

    // Reset state
    rst = 1'b1;
    wait_cycles(4);
    check("rst_clk_oe", kbd_clk_oe, 0);
    check("rst_data_oe", kbd_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_ack", tx_ack, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", tx_ready, 1);
    wait_cycles(3);

    // 0xED with device ACK
    full_frame(8'hED, 1'b1, 1'b0);
    wait_cycles(5);

    // 0x00 with device NACK
    full_frame(8'h00, 1'b0, 1'b0);
    wait_cycles(5);

    // Device never clocks: timeout
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(8'h3C, 1'b0);
    n = 0;
    while (err_cnt == e0 && n < TO_CYC + 50) begin
      n++;
      tick();
    end
    check("timeout_cycles", n, TO_CYC);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_clk_oe", kbd_clk_oe, 0);
    check("timeout_data_oe", kbd_data_oe, 0);
    check("timeout_no_done", done_cnt - d0, 0);
    tick();
    check("timeout_ready", tx_ready, 1);
    check("timeout_err_single", tx_err, 0);
    wait_cycles(5);

    // Reset after edge 4
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(8'h5A, 1'b0);
    send_edges(8'h5A, 4);
    rst = 1'b1;
    tick();
    check("midrst_clk_oe", kbd_clk_oe, 0);
    check("midrst_data_oe", kbd_data_oe, 0);
    check("midrst_busy", busy, 0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(20);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    check("midrst_ready", tx_ready, 1);
    full_frame(8'hFF, 1'b1, 1'b0);
    wait_cycles(5);

    // tx_valid held high with another byte during the frame
    full_frame(8'h96, 1'b1, 1'b1);
    wait_cycles(5);

    // Random bytes and responses
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      ra = bit'($urandom_range(0, 1));
      full_frame(rb, ra, 1'b0);
      wait_cycles(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Sits beside the existing PS/2 receiver in top and shares the kbd_clk/kbd_data open-drain lines.
- Generates the clock-inhibit and request-to-send sequence, shifts the frame out on device clock falling edges, and reports ACK/NACK/timeout.
- Asserts busy so top can gate the receiver during a transmission.

Parameters:
- CLK_FREQ_HZ, 16_000_000, system clock frequency.
- INHIBIT_US, 100, duration kbd_clk is held low before the request; INHIBIT_CYCLES = CLK_FREQ_HZ/1_000_000*INHIBIT_US (1600 at defaults).
- TIMEOUT_CYCLES, 240_000, max cycles between consecutive device clock falling edges (15 ms at 16 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_valid  in  1  command byte valid
- tx_ready  out  1  block idle, can accept a byte
- tx_data  in  8  command byte
- kbd_clk_i  in  1  raw PS/2 clock line (async)
- kbd_clk_oe  out  1  1 = drive kbd_clk low, 0 = release
- kbd_data_i  in  1  raw PS/2 data line (async)
- kbd_data_oe  out  1  1 = drive kbd_data low, 0 = release
- busy  out  1  transmission in progress; top gates the receiver with it
- tx_done  out  1  one-cycle pulse at end of transfer
- tx_ack  out  1  valid with tx_done: 1 = device ACK, 0 = NACK
- tx_err  out  1  one-cycle pulse on timeout; no tx_done for that frame

Behaviour:
- Inputs pass through a 2-FF synchronizer. A falling edge is sync_prev=1 and sync=0.
- All outputs are registered.
- Reset values: kbd_clk_oe=0, kbd_data_oe=0, busy=0, tx_done=0, tx_ack=0, tx_err=0, tx_ready=0 while rst is high. tx_ready=1 the first cycle after rst deasserts. State=IDLE.

State machine:
- IDLE: tx_ready=1, both oe=0. On tx_valid&tx_ready:
  - latch the shift register as {1'b1 stop, odd parity = ~^tx_data, tx_data};
  - go to INHIBIT; tx_ready=0, busy=1 the next cycle.
  - tx_valid while not in IDLE is ignored.
- INHIBIT: kbd_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: one cycle with kbd_clk_oe=1 and kbd_data_oe=1 (start bit). Then go to SEND with kbd_clk_oe=0 and kbd_data_oe still 1.
- SEND: bit counter 0..9.
  - On each kbd_clk falling edge, kbd_data_oe <= ~shift[0], shift right, counter++.
  - Edges 1-8 present data bits LSB first, edge 9 parity, edge 10 stop (release).
  - After edge 10, go to ACK.
- ACK: on the next falling edge, sample kbd_data sync. 0 = ACK, 1 = NACK. Go to WAIT_IDLE.
- WAIT_IDLE: wait until both synced lines read 1. Then pulse tx_done with tx_ack set to the sampled value, go to IDLE, busy=0 the same cycle.
- Timeout: in SEND, ACK and WAIT_IDLE, a counter resets on each falling edge (and on entry to SEND). When it reaches TIMEOUT_CYCLES:
  - both oe=0, tx_err pulses, go to IDLE;
  - tx_done does not pulse.
- Reset mid-frame: both oe drop on the cycle rst is sampled high. Any partial frame is abandoned, with no done or err pulse.
- The receiver must not be driven by this block. busy is the only coupling.

Optional Feature:
- Macro PS2_HOST_TX_RETRY_EN.
- With the macro: a NACK or timeout restarts from INHIBIT with the latched byte, up to 2 retries (3 attempts total).
  - tx_done with tx_ack=0, or tx_err, is emitted only after the final failed attempt.
  - busy stays high across retries.
- Without the macro: single attempt, behaviour as above, and no retry counter is instantiated.

Decomposition:
- ps2_pkg (shared with the receiver):
  - typedef enum for host_tx_state_t (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE);
  - localparam PS2_FRAME_BITS=11;
  - function odd_parity(logic [7:0]).
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge pulse, one instance per line. The receiver reuses it.

Test Plan:
- tx_data=0xED, device model ACKs -> kbd_data released values on edges 1-8 = 1,0,1,1,0,1,1,1; parity=1; stop=1. tx_done pulses with tx_ack=1; busy low the same cycle.
- Any byte -> kbd_clk_oe high for exactly 1600 cycles, then one REQ cycle with both oe=1, then kbd_clk_oe=0 with kbd_data_oe=1.
- tx_data=0x00, model leaves data high on edge 11 -> parity bit 1; tx_done=1 with tx_ack=0; no tx_err.
- Model never clocks after REQ -> tx_err pulse at 240_000 cycles; both oe=0; tx_ready=1 the next cycle. With PS2_HOST_TX_RETRY_EN: three INHIBIT phases, then a single tx_err.
- rst asserted after edge 4 -> both oe=0 the next cycle, no tx_done/tx_err. A new byte 0xFF then sends correctly.
- tx_valid held high with a different byte during SEND -> ignored; the latched byte is transmitted unchanged.
